// File: rtl/stage_if_buf.sv
// Instruction-fetch stage with a credit-limited request port, an in-flight PC queue
// and a decode-facing fetch buffer; redirect flushes and drops stale responses.
module stage_if_buf #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000),
    parameter int unsigned     DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus_4,
    output logic [31:0]     out_instr
);

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0] CREDIT_LIM = (CNT_W + 1)'(DEPTH);

    logic [XLEN-1:0]    fetch_pc;
    logic [CNT_W-1:0]   occupancy;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   drop_cnt;
    logic [PTR_W-1:0]   buf_wr_ptr;
    logic [PTR_W-1:0]   buf_rd_ptr;
    logic [PTR_W-1:0]   ifq_wr_ptr;
    logic [PTR_W-1:0]   ifq_rd_ptr;
    logic [XLEN-1:0]    ifq_pc    [DEPTH];
    logic [XLEN-1:0]    buf_pc    [DEPTH];
    logic [INSTR_W-1:0] buf_instr [DEPTH];

    logic           req_fire;
    logic           rsp_take;
    logic           rsp_keep;
    logic           out_fire;
    logic [CNT_W:0] in_use;
    logic           redirect_pc_unused;

    // Low redirect bits are discarded by word alignment.
    assign redirect_pc_unused = ^redirect_pc[1:0];

    // Handshakes; a redirect suppresses request, keep and pop in its cycle.
    always_comb begin
        in_use         = {1'b0, occupancy} + {1'b0, outstanding};
        imem_req_valid = rst_n && !redirect && (in_use < CREDIT_LIM);
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_take       = imem_rsp_valid && (outstanding != '0);
        rsp_keep       = rsp_take && !redirect && (drop_cnt == '0);
        out_valid      = (occupancy != '0);
        out_fire       = out_valid && out_ready && !redirect;
    end

    assign imem_req_addr = fetch_pc;
    assign out_pc        = buf_pc[buf_rd_ptr];
    assign out_pc_plus_4 = out_pc + XLEN'(32'd4);
    assign out_instr     = buf_instr[buf_rd_ptr];

    // Control state: PC, pointers and the three counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            occupancy   <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            buf_wr_ptr  <= '0;
            buf_rd_ptr  <= '0;
            ifq_wr_ptr  <= '0;
            ifq_rd_ptr  <= '0;
        end else if (redirect) begin
            fetch_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
            occupancy   <= '0;
            buf_wr_ptr  <= '0;
            buf_rd_ptr  <= '0;
            ifq_wr_ptr  <= '0;
            ifq_rd_ptr  <= '0;
            outstanding <= outstanding - CNT_W'(rsp_take);
            drop_cnt    <= outstanding - CNT_W'(rsp_take);
        end else begin
            if (req_fire) begin
                fetch_pc   <= fetch_pc + XLEN'(32'd4);
                ifq_wr_ptr <= ifq_wr_ptr + PTR_W'(1);
            end
            if (rsp_keep) begin
                ifq_rd_ptr <= ifq_rd_ptr + PTR_W'(1);
                buf_wr_ptr <= buf_wr_ptr + PTR_W'(1);
            end
            if (rsp_take && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end
            if (out_fire) begin
                buf_rd_ptr <= buf_rd_ptr + PTR_W'(1);
            end
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_take);
            occupancy   <= occupancy + CNT_W'(rsp_keep) - CNT_W'(out_fire);
        end
    end

    // Storage arrays carry no reset; validity is tracked by the counters.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            ifq_pc[ifq_wr_ptr] <= fetch_pc;
        end
        if (rsp_keep) begin
            buf_pc[buf_wr_ptr]    <= ifq_pc[ifq_rd_ptr];
            buf_instr[buf_wr_ptr] <= imem_rsp_data;
        end
    end

endmodule

// File: doc/stage_if_buf.md
STAGE_IF_BUF -- requirements
Module: stage_if_buf

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC and instruction-address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: fetch PC after reset.
REQ-003 SHALL have parameter DEPTH, default 4: fetch-buffer entries and max outstanding requests; power of 2, >=2.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port redirect  in  1  taken branch/jump; flush and refetch.
REQ-007 SHALL have port redirect_pc  in  XLEN  redirect target.
REQ-008 SHALL have port imem_req_valid  out  1  fetch request valid.
REQ-009 SHALL have port imem_req_ready  in  1  memory accepts request.
REQ-010 SHALL have port imem_req_addr  out  XLEN  fetch address.
REQ-011 SHALL have port imem_rsp_valid  in  1  response valid; responses in request order, latency >=1 cycle, no backpressure.
REQ-012 SHALL have port imem_rsp_data  in  32  fetched instruction.
REQ-013 SHALL have port out_valid  out  1  instruction available to decode.
REQ-014 SHALL have port out_ready  in  1  decode accepts; low = stall (replaces PCWrite).
REQ-015 SHALL have ports out_pc  out  XLEN, out_pc_plus_4  out  XLEN, out_instr  out  32 for the head entry.

Function
REQ-016 SHALL hold fetch_pc; imem_req_addr = fetch_pc; a request fires when imem_req_valid && imem_req_ready, then fetch_pc <= fetch_pc + 4 (wraps modulo 2^XLEN).
REQ-017 SHALL assert imem_req_valid only when redirect = 0 and (buffer occupancy + outstanding) < DEPTH (credit rule; no overflow possible).
REQ-018 SHALL record the address of each fired request in an in-flight PC queue (DEPTH entries) and count outstanding requests (0..DEPTH).
REQ-019 SHALL, on an imem_rsp_valid not marked for drop, pop the in-flight PC and write {pc, imem_rsp_data} to the buffer tail in the same edge; outstanding decrements.
REQ-020 SHALL present the buffer head combinationally: out_valid = occupancy != 0; out_pc_plus_4 = out_pc + 4 (XLEN wrap); pop when out_valid && out_ready.
REQ-021 SHALL support simultaneous push and pop, occupancy unchanged; a full buffer with pop and push in the same cycle is legal.
REQ-022 SHALL give minimum latency: request fire at cycle N, response at N+L -> out_valid at N+L+1.
REQ-023 SHALL, on redirect = 1 at an edge: fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}; buffer emptied; in-flight queue cleared; drop_cnt <= outstanding minus any response arriving that cycle; no request issued that cycle.
REQ-024 SHALL discard responses while drop_cnt != 0, decrementing drop_cnt and outstanding; new-path requests are allowed during drop since ordering guarantees old responses arrive first.
REQ-025 SHALL treat a response arriving in the redirect cycle as dropped, and SHALL not pop the buffer in the redirect cycle regardless of out_ready.
REQ-026 SHALL give redirect priority over every simultaneous request, response and pop.
REQ-027 SHALL never decrement occupancy, outstanding or drop_cnt below zero; an imem_rsp_valid with outstanding = 0 is a protocol error and is ignored.

Reset
REQ-028 SHALL, on rst_n low at any time including mid-transfer, immediately set fetch_pc = RESET_PC, occupancy = 0, outstanding = 0, drop_cnt = 0; then out_valid = 0 and imem_req_valid = 0 while rst_n is low.
REQ-029 SHALL assert imem_req_valid with imem_req_addr = RESET_PC in the first cycle after rst_n deasserts.
REQ-030 SHALL ignore, after reset, responses to requests issued before reset; the memory model is reset together with the block.

Verification
REQ-031 SHALL cover streaming: ready memory, latency 1, out_ready = 1 -> out_pc 0,4,8,... one per cycle; out_instr matches memory.
REQ-032 SHALL cover backpressure: out_ready = 0 -> exactly DEPTH requests (0x0..0xC), imem_req_valid low, buffer full; raise out_ready -> 0x10 requested; no loss or duplication.
REQ-033 SHALL cover a flush with 3 outstanding: redirect to 0x100 -> next request addr 0x100, three old responses dropped, first out_pc = 0x100.
REQ-034 SHALL cover a redirect coinciding with a response and out_ready = 1 -> response dropped, no pop counted, out_valid = 0 next cycle.
REQ-035 SHALL cover alignment and wrap: redirect_pc = 0x102 -> fetch at 0x100; redirect_pc = 0xFFFF_FFFC -> out_pc_plus_4 = 0x0, next fetch 0x0.
REQ-036 SHALL cover async reset mid-burst: rst_n low between edges -> outputs clear without a clock edge; after release first request at RESET_PC.
